// File: rtl/wm_phase_timer_if.sv
// Phase-timer link between the washer controller and wm_phase_timer.
// Latency: none in the interface itself; the timer registers every output one edge after its inputs.
// Backpressure: none; completion pulses are single-cycle and must be sampled when they appear.
//
// Signals:
//   soak_en/wash_en/rinse_en/spin_en : phase enables (one-hot or all zero)
//   mode1/mode2/mode3                : wash-mode selects (duration multiplier)
//   lid, cancel                      : pause while lid open, clear on cancel
//   timer_soak/.../timer_spin        : one-cycle completion pulses
//   remaining                        : ticks left in the active phase
//   phase_err                        : more than one enable high
interface wm_phase_timer_if #(
   parameter int CNT_W = 16
);
   logic             soak_en;
   logic             wash_en;
   logic             rinse_en;
   logic             spin_en;
   logic             mode1;
   logic             mode2;
   logic             mode3;
   logic             lid;
   logic             cancel;
   logic             timer_soak;
   logic             timer_wash;
   logic             timer_rinse;
   logic             timer_spin;
   logic [CNT_W-1:0] remaining;
   logic             phase_err;

   // Controller side: drives enables and conditions, receives completions.
   modport master (
      output soak_en, wash_en, rinse_en, spin_en,
      output mode1, mode2, mode3, lid, cancel,
      input  timer_soak, timer_wash, timer_rinse, timer_spin,
      input  remaining, phase_err
   );

   // Timer side.
   modport slave (
      input  soak_en, wash_en, rinse_en, spin_en,
      input  mode1, mode2, mode3, lid, cancel,
      output timer_soak, timer_wash, timer_rinse, timer_spin,
      output remaining, phase_err
   );
endinterface

// File: rtl/wm_phase_timer.sv
// Phase-duration timer: answers a one-hot phase enable with a completion pulse after base*mode ticks.
// Latency: pulse is high in the cycle after entry edge + target*TICK_DIV; remaining/phase_err lag inputs by one edge.
// Backpressure: none; lid=1 pauses the count, cancel clears it, pulses are never held or retried.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : wm_phase_timer_if.slave (enables, modes, lid, cancel in; pulses, remaining, phase_err out)
module wm_phase_timer #(
   parameter int TICK_DIV = 1000,
   parameter int CNT_W    = 16,
   parameter int SOAK_T   = 3,
   parameter int WASH_T   = 5,
   parameter int RINSE_T  = 4,
   parameter int SPIN_T   = 2
) (
   input  logic            clk,
   input  logic            rst,
   wm_phase_timer_if.slave bus
);

   localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

   // A zero base duration would never complete; treat it as one tick.
   localparam logic [CNT_W-1:0] SOAK_B  = CNT_W'((SOAK_T  == 0) ? 1 : SOAK_T);
   localparam logic [CNT_W-1:0] WASH_B  = CNT_W'((WASH_T  == 0) ? 1 : WASH_T);
   localparam logic [CNT_W-1:0] RINSE_B = CNT_W'((RINSE_T == 0) ? 1 : RINSE_T);
   localparam logic [CNT_W-1:0] SPIN_B  = CNT_W'((SPIN_T  == 0) ? 1 : SPIN_T);

   logic [3:0]       en;
   logic [3:0]       prev_en;
   logic [PW-1:0]    presc;
   logic [CNT_W-1:0] t;
   logic [CNT_W-1:0] t_inc;
   logic             done;
   logic [1:0]       mult;
   logic [1:0]       mult_nxt;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] target_nxt;
   logic [3:0]       pulse_q;
   logic [CNT_W-1:0] rem_q;
   logic             phase_err_q;
   logic             en_none;
   logic             en_multi;
   logic             en_entry;
   logic             tick;

   function automatic logic [CNT_W-1:0] base_of(input logic [3:0] v);
      logic [CNT_W-1:0] b;
      b = SOAK_B;
      if (v[1]) b = WASH_B;
      if (v[2]) b = RINSE_B;
      if (v[3]) b = SPIN_B;
      return b;
   endfunction

   function automatic logic [CNT_W-1:0] scale(input logic [CNT_W-1:0] b, input logic [1:0] m);
      logic [CNT_W-1:0] r;
      case (m)
         2'd3:    r = b + (b << 1);
         2'd2:    r = b << 1;
         default: r = b;
      endcase
      return r;
   endfunction

   assign en = {bus.spin_en, bus.rinse_en, bus.wash_en, bus.soak_en};

   assign en_none  = (en == 4'b0000);
   assign en_multi = ((en & (en - 4'd1)) != 4'b0000);
   // Entry: one-hot and different from what was sampled last; prev_en is zeroed by
   // cancel, idle and reset so that a still-high enable re-enters afterwards.
   assign en_entry = !en_none && !en_multi && (en != prev_en);

   assign mult_nxt   = bus.mode3 ? 2'd3 :
                       bus.mode2 ? 2'd2 :
                       bus.mode1 ? 2'd1 : 2'd1;
   assign target_nxt = scale(base_of(en), mult_nxt);
   // While running, prev_en equals the active phase, so the target follows from it.
   assign target     = scale(base_of(prev_en), mult);
   assign t_inc      = t + CNT_W'(1);
   assign tick       = (presc == PRESC_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_en     <= 4'b0000;
         presc       <= '0;
         t           <= '0;
         done        <= 1'b0;
         mult        <= 2'd1;
         pulse_q     <= 4'b0000;
         rem_q       <= '0;
         phase_err_q <= 1'b0;
      end else begin
         pulse_q     <= 4'b0000;
         phase_err_q <= en_multi;
         if (en_none) begin
            presc   <= '0;
            t       <= '0;
            done    <= 1'b0;
            rem_q   <= '0;
            prev_en <= 4'b0000;
         end else if (en_multi) begin
            // Remember the illegal vector so a return to one-hot is a fresh entry.
            presc   <= '0;
            t       <= '0;
            done    <= 1'b0;
            rem_q   <= '0;
            prev_en <= en;
         end else if (bus.cancel) begin
            presc   <= '0;
            t       <= '0;
            done    <= 1'b0;
            rem_q   <= '0;
            prev_en <= 4'b0000;
         end else if (en_entry) begin
            presc   <= '0;
            t       <= '0;
            done    <= 1'b0;
            mult    <= mult_nxt;
            rem_q   <= target_nxt;
            prev_en <= en;
         end else if (bus.lid || done) begin
            // Paused or finished: hold everything. Done also swallows the
            // controller's one-cycle enable lag after completion.
         end else if (tick) begin
            presc <= '0;
            t     <= t_inc;
            if (t_inc == target) begin
               pulse_q <= en;
               done    <= 1'b1;
               rem_q   <= '0;
            end else begin
               rem_q <= target - t_inc;
            end
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

   assign bus.timer_soak  = pulse_q[0];
   assign bus.timer_wash  = pulse_q[1];
   assign bus.timer_rinse = pulse_q[2];
   assign bus.timer_spin  = pulse_q[3];
   assign bus.remaining   = rem_q;
   assign bus.phase_err   = phase_err_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Bench for wm_phase_timer: expected completion pulses are queued at stimulus time
// and matched (phase and edge number) by a monitor when the DUT pulses.
// Also checks reset state, remaining, phase_err and async reset directly.
module tb_wm_phase_timer;

   localparam int TD    = 4;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [3:0]  ph;
      logic [31:0] cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   int unsigned cyc;
   int          n_chk;
   int          n_err;
   exp_t        sb[$];
   int unsigned e0;

   wm_phase_timer_if #(.CNT_W(CNT_W)) bus();

   wm_phase_timer #(
      .TICK_DIV (TD),
      .CNT_W    (CNT_W),
      .SOAK_T   (3),
      .WASH_T   (5),
      .RINSE_T  (4),
      .SPIN_T   (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // cyc == N after the Nth rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [3:0] pulses();
      return {bus.timer_spin, bus.timer_rinse, bus.timer_wash, bus.timer_soak};
   endfunction

   // Scoreboard consumer: every pulse observed must match the head of the queue.
   always @(negedge clk) begin
      exp_t e;
      if (pulses() != 4'b0000) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {28'd0, pulses()}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("pulse_phase", {28'd0, pulses()}, {28'd0, e.ph});
            chk("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic idle_inputs();
      bus.soak_en  = 1'b0;
      bus.wash_en  = 1'b0;
      bus.rinse_en = 1'b0;
      bus.spin_en  = 1'b0;
      bus.mode1    = 1'b0;
      bus.mode2    = 1'b0;
      bus.mode3    = 1'b0;
      bus.lid      = 1'b0;
      bus.cancel   = 1'b0;
   endtask

   task automatic push(input logic [3:0] ph, input int unsigned at);
      exp_t e;
      e.ph  = ph;
      e.cyc = at;
      sb.push_back(e);
   endtask

   initial begin
      cyc   = 0;
      n_chk = 0;
      n_err = 0;
      rst   = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("rst_remaining", {16'd0, bus.remaining}, 32'd0);
      chk("rst_phase_err", {31'd0, bus.phase_err}, 32'd0);
      chk("rst_pulses", {28'd0, pulses()}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1) soak, mode1: target 3 ticks -> pulse after E0+12, remaining 3,2,1,0
      bus.mode1   = 1'b1;
      bus.soak_en = 1'b1;
      e0 = cyc + 1;
      push(4'b0001, e0 + 3 * TD);
      @(negedge clk);
      chk("soak_rem3", {16'd0, bus.remaining}, 32'd3);
      repeat (TD) @(negedge clk);
      chk("soak_rem2", {16'd0, bus.remaining}, 32'd2);
      repeat (TD) @(negedge clk);
      chk("soak_rem1", {16'd0, bus.remaining}, 32'd1);
      repeat (TD) @(negedge clk);
      chk("soak_rem0", {16'd0, bus.remaining}, 32'd0);
      repeat (4) @(negedge clk);
      bus.soak_en = 1'b0;
      repeat (2) @(negedge clk);

      // 2) soak, mode3+mode1: multiplier 3 -> pulse after E0+36, no second pulse while held
      bus.mode3   = 1'b1;
      bus.soak_en = 1'b1;
      e0 = cyc + 1;
      push(4'b0001, e0 + 9 * TD);
      @(negedge clk);
      chk("soak_x3_rem9", {16'd0, bus.remaining}, 32'd9);
      repeat (9 * TD + 5) @(negedge clk);
      chk("soak_x3_done_rem", {16'd0, bus.remaining}, 32'd0);
      bus.soak_en = 1'b0;
      bus.mode3   = 1'b0;
      repeat (2) @(negedge clk);

      // 3) wash with lid open for 7 cycles: pulse moves from E0+20 to E0+27
      bus.wash_en = 1'b1;
      e0 = cyc + 1;
      push(4'b0010, e0 + 5 * TD + 7);
      @(negedge clk);
      repeat (5) @(negedge clk);
      bus.lid = 1'b1;
      repeat (3) @(negedge clk);
      chk("wash_lid_rem_held", {16'd0, bus.remaining}, 32'd4);
      repeat (4) @(negedge clk);
      bus.lid = 1'b0;
      repeat (20) @(negedge clk);
      bus.wash_en = 1'b0;
      repeat (2) @(negedge clk);

      // 4) rinse with cancel sampled at E0+10: restart, pulse 16 after the re-entry edge
      bus.rinse_en = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      repeat (9) @(negedge clk);
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
      e0 = cyc + 1;
      push(4'b0100, e0 + 4 * TD);
      @(negedge clk);
      chk("rinse_reentry_rem", {16'd0, bus.remaining}, 32'd4);
      repeat (4 * TD + 3) @(negedge clk);
      bus.rinse_en = 1'b0;
      repeat (2) @(negedge clk);

      // 5) soak+wash together: phase_err, remaining 0, no pulses; drop soak -> wash runs
      bus.soak_en = 1'b1;
      bus.wash_en = 1'b1;
      @(negedge clk);
      chk("multi_phase_err", {31'd0, bus.phase_err}, 32'd1);
      chk("multi_rem", {16'd0, bus.remaining}, 32'd0);
      repeat (6) @(negedge clk);
      chk("multi_phase_err_held", {31'd0, bus.phase_err}, 32'd1);
      bus.soak_en = 1'b0;
      e0 = cyc + 1;
      push(4'b0010, e0 + 5 * TD);
      @(negedge clk);
      chk("multi_exit_phase_err", {31'd0, bus.phase_err}, 32'd0);
      chk("multi_exit_rem", {16'd0, bus.remaining}, 32'd5);
      repeat (5 * TD + 3) @(negedge clk);
      bus.wash_en = 1'b0;
      repeat (2) @(negedge clk);

      // 6) spin, mode2 (target 4 -> 16 cycles): async reset at E0+9 kills the phase
      bus.mode1   = 1'b0;
      bus.mode2   = 1'b1;
      bus.spin_en = 1'b1;
      @(negedge clk);
      repeat (9) @(negedge clk);
      chk("spin_rem_before_rst", {16'd0, bus.remaining}, 32'd2);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_rem", {16'd0, bus.remaining}, 32'd0);
      chk("async_rst_phase_err", {31'd0, bus.phase_err}, 32'd0);
      chk("async_rst_pulses", {28'd0, pulses()}, 32'd0);
      bus.spin_en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      bus.spin_en = 1'b1;
      e0 = cyc + 1;
      push(4'b1000, e0 + 4 * TD);
      @(negedge clk);
      chk("spin_reentry_rem", {16'd0, bus.remaining}, 32'd4);
      repeat (4 * TD + 3) @(negedge clk);
      bus.spin_en = 1'b0;
      repeat (4) @(negedge clk);

      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/wm_phase_timer.md
# wm_phase_timer

Phase-duration timer for the washing-machine controller. It answers the controller's registered phase enables (`soak_en`, `wash_en`, `rinse_en`, `spin_en`) with one-cycle completion pulses (`timer_soak`, `timer_wash`, `timer_rinse`, `timer_spin`) once the mode-scaled duration of the active phase has elapsed. It sits between the controller's output registers and its timer inputs. It also pauses while the lid is open, clears on cancel, and reports the remaining time.

## Interface
- `TICK_DIV`, 1000: clock cycles per timer tick; legal range is ≥1.
- `CNT_W`, 16: width of the tick counter and of `remaining`.
- `SOAK_T`, 3: base soak duration in ticks. A value of 0 is treated as 1.
- `WASH_T`, 5: base wash duration in ticks. A value of 0 is treated as 1.
- `RINSE_T`, 4: base rinse duration in ticks. A value of 0 is treated as 1.
- `SPIN_T`, 2: base spin duration in ticks. A value of 0 is treated as 1.
- `clk` in 1: the single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `soak_en`, `wash_en`, `rinse_en`, `spin_en` in 1 each: phase enables from the controller; one-hot or all zero.
- `mode1`, `mode2`, `mode3` in 1 each: wash-mode selects.
- `lid` in 1: 1 = open. The count pauses while it is 1.
- `cancel` in 1: clears the count.
- `timer_soak`, `timer_wash`, `timer_rinse`, `timer_spin` out 1 each: registered one-cycle completion pulses.
- `remaining` out CNT_W: ticks left in the active phase; 0 when no phase is active.
- `phase_err` out 1: registered; 1 while more than one enable is high.

## Operation
- Reset values: all `timer_*` = 0, `remaining` = 0, `phase_err` = 0. Internally: prescaler = 0, tick count `t` = 0, done flag = 0, multiplier = 1, previous-enable register = 0.
- Phase entry: an edge at which the sampled enable vector is one-hot and differs from the previous sampled vector. At entry:
  - `t` ← 0, prescaler ← 0, done ← 0.
  - Multiplier is latched by priority: `mode3` → 3, else `mode2` → 2, else `mode1` → 1, else 1.
  - `target` ← base × multiplier. `CNT_W` must hold 3 × the largest base; this is a parameter rule with no runtime check.
- Running: the enable stays the same, `lid`=0, `cancel`=0, and done=0. On each such edge:
  - If prescaler == `TICK_DIV`−1: prescaler ← 0, `t` ← `t`+1 (a tick). Otherwise prescaler increments.
- Completion: on the tick edge where `t`+1 == `target`:
  - The matching `timer_*` is registered 1 for exactly one cycle.
  - done ← 1, and counting stops.
  - No further pulse is issued until the next phase entry. This covers the controller's one-cycle enable lag after its state changes.
- Lid open (`lid`=1): prescaler and `t` hold. Each paused cycle adds one cycle to the phase. A `cancel` sampled during the pause still clears.
- Cancel (`cancel`=1 sampled): prescaler, `t` and done ← 0. No pulse is produced that cycle. If an enable is still high after `cancel` falls, the next edge is treated as a fresh phase entry.
- All enables 0: prescaler, `t` and done ← 0, `remaining` = 0, and the previous-enable register ← 0.
- More than one enable high:
  - `phase_err` = 1 and counters are held at 0.
  - No pulses are produced and `remaining` = 0.
  - A return to one-hot is a fresh entry.
- `remaining` = `target` − `t` while a phase is active and not done; 0 once done. It updates at the same edge as `t`.
- Reset asserted mid-phase: all state returns to reset values immediately, without waiting for a clock edge. After release, counting restarts only on a fresh entry.

## Timing
- Entry to pulse: with `lid`=0 and no cancel, the pulse is high in the cycle after edge E0 + `target`×`TICK_DIV`, where E0 is the entry edge.
- Pulse width: exactly 1 cycle. Pulses for different phases never overlap.
- `phase_err` and `remaining` are registered with one edge of latency from their inputs.
- Simultaneous events at the final tick edge:
  - `cancel` wins: no pulse is produced.
  - `lid`=1 wins: the tick is deferred.
  - An enable change wins: it is a new entry and no pulse is produced for the old phase.

## Test plan
- `TICK_DIV`=4, `SOAK_T`=3, `mode1`=1, `soak_en` raised at E0 → `timer_soak` is high for exactly 1 cycle after edge E0+12. `remaining` steps 3,2,1,0.
- Same setup with `mode3`=1 and `mode1`=1 → the multiplier is 3 and the pulse is at E0+36. Holding `soak_en` for 5 further cycles after the pulse → no second pulse.
- `WASH_T`=5 with `lid`=1 for 7 cycles mid-phase → the pulse moves from E0+20 to E0+27.
- `RINSE_T`=4 with `cancel` pulsed at E0+10 while `rinse_en` stays high → no pulse at E0+16. The count restarts, and the pulse lands 16 cycles after the post-cancel entry edge.
- `soak_en`=`wash_en`=1 together → `phase_err`=1, `remaining`=0, no pulses. Drop `soak_en` → `phase_err`=0 and the wash pulse arrives after `WASH_T`×`TICK_DIV` cycles.
- Assert `rst` asynchronously at E0+9 of a spin phase → all outputs are 0 immediately and no `timer_spin` follows. Re-raise `spin_en` → the full duration elapses before the pulse.
